sixty_four_bit_serial_subtractor: RTL and testbench

SIXTY_FOUR_BIT_SERIAL_SUBTRACTOR -- requirements
Module: sixty_four_bit_serial_subtractor

---
 rtl/sixty_four_bit_serial_subtractor.sv | 134 +++++++++++++
 tb/tb_sixty_four_bit_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sixty_four_bit_serial_subtractor.sv
// sixty_four_bit_serial_subtractor
//
// Purpose:
//   Computes Diff = A - B - Bin (mod 2^64) and the borrow-out.
//   The subtraction runs serially, one SLICE_W-bit slice per clock.
//   Starting from the least significant slice, each slice's borrow
//   feeds the next slice. Diff and Borrow are registered and change
//   together only when the last slice completes, or on reset.
//
// Parameters:
//   SLICE_W : slice width per cycle; must be 8, 16 or 32.
//             NSLICE = 64/SLICE_W is the number of processing cycles.
//
// Ports:
//   clk    : in   1  rising-edge clock
//   rst    : in   1  synchronous active-high reset
//   start  : in   1  begin a subtraction; accepted in IDLE or DONE
//   A      : in  64  unsigned minuend, latched on an accepted start
//   B      : in  64  unsigned subtrahend, latched on an accepted start
//   Bin    : in   1  borrow-in, latched on an accepted start
//   Diff   : out 64  registered difference
//   Borrow : out  1  registered borrow-out (A < B + Bin)
//   busy   : out  1  high while slices are being processed
//   done   : out  1  one-cycle completion pulse

module sixty_four_bit_serial_subtractor #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Bin,
  output logic [63:0] Diff,
  output logic        Borrow,
  output logic        busy,
  output logic        done
);

  localparam int NSLICE = 64 / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int ACC_W  = 64 - SLICE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [63:0]      a_sh;
  logic [63:0]      b_sh;
  logic             borrow_chain;
  logic [IDX_W-1:0] slice_idx;
  logic [ACC_W-1:0] acc;
  logic [SLICE_W:0] slice_res;
  logic [63:0]      full_res;
  logic             accept;
  logic             last_slice;

  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_slice = (slice_idx == LAST_IDX);

  // Unsigned (SLICE_W+1)-bit slice difference.
  // The operands are at most 2^SLICE_W - 1 apart, so the MSB is set
  // exactly when the slice underflows. That MSB is the slice borrow.
  assign slice_res = {1'b0, a_sh[SLICE_W-1:0]}
                   - {1'b0, b_sh[SLICE_W-1:0]}
                   - {{SLICE_W{1'b0}}, borrow_chain};

  // Completed slices sit in acc, oldest at the bottom.
  // Putting the current slice on top gives the full word after the
  // last slice, and the shifted accumulator for intermediate slices.
  assign full_res = {slice_res[SLICE_W-1:0], acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_slice) state_next = DONE;
      DONE: state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operands shift right one slice per RUN edge, so the active slice
  // is always in the low bits. Diff and Borrow load only on the last
  // slice, so partial results never appear on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh         <= '0;
      b_sh         <= '0;
      borrow_chain <= 1'b0;
      slice_idx    <= '0;
      acc          <= '0;
      Diff         <= '0;
      Borrow       <= 1'b0;
    end else if (accept) begin
      a_sh         <= A;
      b_sh         <= B;
      borrow_chain <= Bin;
      slice_idx    <= '0;
    end else if (state == RUN) begin
      a_sh         <= a_sh >> SLICE_W;
      b_sh         <= b_sh >> SLICE_W;
      borrow_chain <= slice_res[SLICE_W];
      acc          <= full_res[63:SLICE_W];
      if (last_slice) begin
        Diff   <= full_res;
        Borrow <= slice_res[SLICE_W];
      end else begin
        slice_idx <= slice_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sixty_four_bit_serial_subtractor.sv
// tb_sixty_four_bit_serial_subtractor
//
// Purpose:
//   Self-checking bench for sixty_four_bit_serial_subtractor at the
//   default slice width. Expected results come from plain 64-bit
//   arithmetic on the operands. Inputs change on falling edges, and
//   outputs are sampled on falling edges.
//
// Ports: none (top-level bench).

module tb_sixty_four_bit_serial_subtractor;

  localparam int SLICE_W = 16;
  localparam int NSLICE  = 64 / SLICE_W;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        Bin;
  logic [63:0] Diff;
  logic        Borrow;
  logic        busy;
  logic        done;

  int tests;
  int failures;
  logic [63:0] last_diff;

  sixty_four_bit_serial_subtractor #(.SLICE_W(SLICE_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .Bin    (Bin),
    .Diff   (Diff),
    .Borrow (Borrow),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] refDiff(input logic [63:0] a, input logic [63:0] b, input logic bin);
    return a - b - 64'(bin);
  endfunction

  function automatic logic refBorrow(input logic [63:0] a, input logic [63:0] b, input logic bin);
    logic [64:0] need;
    need = {1'b0, b} + 65'(bin);
    return ({1'b0, a} < need);
  endfunction

  task automatic applyStimulus(input logic st, input logic [63:0] a, input logic [63:0] b, input logic bin);
    start = st;
    A     = a;
    B     = b;
    Bin   = bin;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete operation. Start is driven before edge N, and the
  // operands are scrambled afterwards. Each check runs on a falling
  // edge. busy must be high for NSLICE cycles with Diff unchanged,
  // and done is then checked together with the result.
  task automatic runOp(input string tag, input logic [63:0] a, input logic [63:0] b, input logic bin);
    applyStimulus(1'b1, a, b, bin);
    @(negedge clk);
    applyStimulus(1'b0, 64'($urandom) << 32 | 64'($urandom), 64'($urandom), 1'($urandom));
    for (int i = 1; i <= NSLICE; i++) begin
      checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
      checkOutput({tag, "_nodone"}, 64'(done), 64'd0);
      checkOutput({tag, "_hold"}, Diff, last_diff);
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    checkOutput({tag, "_diff"}, Diff, refDiff(a, b, bin));
    checkOutput({tag, "_borrow"}, 64'(Borrow), 64'(refBorrow(a, b, bin)));
    last_diff = refDiff(a, b, bin);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] ops_a [3];
    logic [63:0] ops_b [3];
    logic        ops_c [3];
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    int          ndone;
    int          last_cyc;

    tests     = 0;
    failures  = 0;
    last_diff = 64'h0;
    rst       = 1'b1;
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_diff", Diff, 64'h0);
    checkOutput("rst_borrow", 64'(Borrow), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases
    runOp("xslice", 64'h0000_0000_0001_0000, 64'h1, 1'b0);
    runOp("wrap", 64'h0, 64'h0, 1'b1);
    runOp("msb_eq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    runOp("small_neg", 64'h5, 64'h6, 1'b0);
    runOp("max_minus", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      ra = {32'($urandom), 32'($urandom)};
      rb = {32'($urandom), 32'($urandom)};
      rc = 1'($urandom);
      if (i == 0) rb = ra;
      runOp("rand", ra, rb, rc);
    end

    // Start pulsed during RUN must be ignored
    ra = 64'h1234_5678_9ABC_DEF0;
    rb = 64'h0FED_CBA9_8765_4321;
    applyStimulus(1'b1, ra, rb, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 64'hDEAD_BEEF_0000_0001, 64'h1111_2222_3333_4444, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
    repeat (NSLICE - 2) @(negedge clk);
    checkOutput("ign_done", 64'(done), 64'd1);
    checkOutput("ign_diff", Diff, refDiff(ra, rb, 1'b1));
    checkOutput("ign_borrow", 64'(Borrow), 64'(refBorrow(ra, rb, 1'b1)));
    last_diff = refDiff(ra, rb, 1'b1);
    @(negedge clk);
    checkOutput("ign_after", 64'(busy), 64'd0);

    // Back-to-back operation with start held high
    for (int k = 0; k < 3; k++) begin
      ops_a[k] = {32'($urandom), 32'($urandom)};
      ops_b[k] = {32'($urandom), 32'($urandom)};
      ops_c[k] = 1'($urandom);
    end
    applyStimulus(1'b1, ops_a[0], ops_b[0], ops_c[0]);
    ndone    = 0;
    last_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 3) begin
          checkOutput("b2b_diff", Diff, refDiff(ops_a[ndone], ops_b[ndone], ops_c[ndone]));
          checkOutput("b2b_borrow", 64'(Borrow), 64'(refBorrow(ops_a[ndone], ops_b[ndone], ops_c[ndone])));
          last_diff = refDiff(ops_a[ndone], ops_b[ndone], ops_c[ndone]);
        end
        if (ndone > 0) checkOutput("b2b_gap", 64'(c - last_cyc), 64'(NSLICE + 1));
        last_cyc = c;
        ndone++;
        if (ndone < 3) applyStimulus(1'b1, ops_a[ndone], ops_b[ndone], ops_c[ndone]);
        else applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
      end
    end
    checkOutput("b2b_count", 64'(ndone), 64'd3);

    // Reset in the middle of RUN aborts and clears the result
    applyStimulus(1'b1, 64'hFFFF_0000_FFFF_0000, 64'h1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_diff", Diff, 64'h0);
    checkOutput("abort_borrow", 64'(Borrow), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    ndone = 0;
    for (int c = 0; c < 2 * NSLICE; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checkOutput("abort_nodone", 64'(ndone), 64'd0);
    last_diff = 64'h0;

    // Reset wins over start on the same edge
    rst = 1'b1;
    applyStimulus(1'b1, 64'h7, 64'h3, 1'b0);
    @(negedge clk);
    checkOutput("rst_start_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    checkOutput("rst_start_idle", 64'(busy), 64'd0);

    // First start after reset is accepted normally
    runOp("post_rst", {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
